// File: rtl/cron_calc_ctrl_if.sv
// ---------------------------------------------------------------------------
// cron_calc_ctrl_if
//   Connects the keypad decoder, the cron/calc controller and the display
//   driver.
//
//   Key protocol: key is a level code. 31 means no key is down. The code is
//   held for as long as the key is pressed. The controller treats a change
//   from 31 to any other code as one press. There is no valid/ready pair.
//   The keypad side drives key on every cycle. The controller drives every
//   display field on every cycle from registers, so the display driver can
//   sample them at any time.
//
//   Parameters (must match the controller instance)
//     SEG_W     seconds counter width
//     OP_W      calculator operand width
//     NUM_LAPS  lap buffer depth
//
//   Modports
//     master  keypad/display side: drives key, observes everything else
//     slave   controller side: samples key, drives everything else
// ---------------------------------------------------------------------------
interface cron_calc_ctrl_if #(
    parameter int SEG_W    = 10,
    parameter int OP_W     = 7,
    parameter int NUM_LAPS = 4
);
    localparam int LC_W = $clog2(NUM_LAPS + 1);

    logic [4:0]        key;
    logic              modo_atual;
    logic              running;
    logic [3:0]        decs;
    logic [SEG_W-1:0]  segs;
    logic              ovf;
    logic [OP_W-1:0]   X;
    logic [OP_W-1:0]   Y;
    logic              op;
    logic [2*OP_W-1:0] resultado;
    logic [LC_W-1:0]   lap_count;
    logic [3:0]        lap_decs;
    logic [SEG_W-1:0]  lap_segs;

    modport master (
        output key,
        input  modo_atual, running, decs, segs, ovf, X, Y, op, resultado,
               lap_count, lap_decs, lap_segs
    );

    modport slave (
        input  key,
        output modo_atual, running, decs, segs, ovf, X, Y, op, resultado,
               lap_count, lap_decs, lap_segs
    );
endinterface

// File: rtl/cron_calc_ctrl.sv
// ---------------------------------------------------------------------------
// cron_calc_ctrl
//   Keypad-driven stopwatch / calculator controller. It sits between the
//   keypad decoder and the display driver.
//   - The key code is registered once. A press is detected on the edge where
//     the code leaves 31 (no key).
//   - The mode FSM selects CRON or CALC. modo_atual is the FSM state register
//     itself, so the current state is always visible.
//   - A background stopwatch counts deciseconds and seconds. It runs in both
//     modes and has a sticky overflow flag.
//   - CALC mode takes decimal operand entry into X or Y and computes a
//     registered add or multiply result.
//   - An optional lap buffer records the count when B is pressed while the
//     stopwatch runs.
//
//   Build option
//     CRON_LAP_EN  when defined, the lap buffer is present. When undefined,
//                  lap_count, lap_decs and lap_segs read as 0, and B while
//                  running is ignored.
//
//   Ports
//     clk    system clock
//     rst_n  synchronous reset, active low
//     bus    cron_calc_ctrl_if.slave
//              key in; mode, stopwatch, calculator and lap fields out
// ---------------------------------------------------------------------------
module cron_calc_ctrl #(
    parameter int CLK_HZ   = 1000,
    parameter int SEG_W    = 10,
    parameter int OP_W     = 7,
    parameter int NUM_LAPS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cron_calc_ctrl_if.slave bus
);
    localparam int PRE_N = CLK_HZ / 10;
    localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
    localparam int LC_W  = $clog2(NUM_LAPS + 1);
    localparam int ACC_W = OP_W + 4;   // 10*(2^OP_W-1)+9 always fits
    localparam int RES_W = 2 * OP_W;

    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd31;

    typedef enum logic {
        MODE_CRON = 1'b0,
        MODE_CALC = 1'b1
    } mode_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [4:0]       key_r;
    logic [4:0]       key_prev;
    mode_t            mode_q;
    logic             running_q;
    logic [PRE_W-1:0] pre_q;
    logic [3:0]       decs_q;
    logic [SEG_W-1:0] segs_q;
    logic             ovf_q;
    logic [OP_W-1:0]  x_q;
    logic [OP_W-1:0]  y_q;
    logic             op_q;
    logic             ptr_y_q;   // entry pointer: 0 -> X, 1 -> Y
    logic [RES_W-1:0] res_q;

    // -----------------------------------------------------------------------
    // Press decode
    // -----------------------------------------------------------------------
    logic             press;
    logic             cron_ev;
    logic             calc_ev;
    logic             key_digit;
    logic             tick;
    logic             sw_clear;
    logic [OP_W-1:0]  entry_tgt;
    logic [ACC_W-1:0] entry_acc;
    logic             entry_fits;

    assign press     = (key_r != KEY_NONE) && (key_prev == KEY_NONE);
    assign cron_ev   = press && (mode_q == MODE_CRON);
    assign calc_ev   = press && (mode_q == MODE_CALC);
    assign key_digit = (key_r <= 5'd9);

    // The tick only fires while running. A stopped prescaler keeps its
    // partial count, so a later restart loses no time.
    assign tick      = running_q && (pre_q == PRE_LAST);

    // B while stopped zeroes the stopwatch. It never overlaps a tick,
    // because a tick needs the stopwatch to be running.
    assign sw_clear  = cron_ev && (key_r == KEY_B) && !running_q;

    // Decimal entry: shift the selected operand left by one digit. The
    // digit is accepted only if the result still fits in OP_W bits.
    assign entry_tgt  = ptr_y_q ? y_q : x_q;
    assign entry_acc  = ACC_W'(entry_tgt) * ACC_W'(10) + ACC_W'(key_r[3:0]);
    assign entry_fits = (entry_acc[ACC_W-1:OP_W] == 4'd0);

    // -----------------------------------------------------------------------
    // Key history
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_r    <= KEY_NONE;
            key_prev <= KEY_NONE;
        end else begin
            key_r    <= bus.key;
            key_prev <= key_r;
        end
    end

    // -----------------------------------------------------------------------
    // Mode FSM. The mode-changing press does nothing else. The CRON and
    // CALC blocks only look at presses in their own current mode.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_CRON;
        end else begin
            case (mode_q)
                MODE_CRON: if (cron_ev && (key_r == KEY_STAR || key_r == KEY_HASH))
                               mode_q <= MODE_CALC;
                MODE_CALC: if (calc_ev && key_r == KEY_D)
                               mode_q <= MODE_CRON;
                default:   mode_q <= MODE_CRON;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stopwatch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            pre_q     <= '0;
            decs_q    <= 4'd0;
            segs_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (cron_ev && key_r == KEY_A)
                running_q <= !running_q;

            if (sw_clear) begin
                pre_q  <= '0;
                decs_q <= 4'd0;
                segs_q <= '0;
                ovf_q  <= 1'b0;
            end else if (tick) begin
                pre_q <= '0;
                if (decs_q == 4'd9) begin
                    decs_q <= 4'd0;
                    if (segs_q == {SEG_W{1'b1}}) begin
                        segs_q <= '0;
                        ovf_q  <= 1'b1;
                    end else begin
                        segs_q <= segs_q + SEG_W'(1);
                    end
                end else begin
                    decs_q <= decs_q + 4'd1;
                end
            end else if (running_q) begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Calculator operands. They are untouched in CRON mode, so they persist
    // across mode changes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 1'b0;
            ptr_y_q <= 1'b0;
        end else if (calc_ev) begin
            if (key_digit) begin
                if (entry_fits) begin
                    if (ptr_y_q) y_q <= entry_acc[OP_W-1:0];
                    else         x_q <= entry_acc[OP_W-1:0];
                end
            end else begin
                case (key_r)
                    KEY_STAR: begin op_q <= 1'b1; ptr_y_q <= 1'b1; end
                    KEY_HASH: begin op_q <= 1'b0; ptr_y_q <= 1'b1; end
                    KEY_C: begin
                        x_q     <= '0;
                        y_q     <= '0;
                        op_q    <= 1'b0;
                        ptr_y_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The result is 2*OP_W wide, so neither the sum nor the product can
    // overflow. It trails any operand or op change by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= op_q ? (RES_W'(x_q) * RES_W'(y_q))
                                  : (RES_W'(x_q) + RES_W'(y_q));
    end

    // -----------------------------------------------------------------------
    // Lap buffer. Only the latest capture is visible on the outputs, so only
    // that capture is held. The count tracks how full the buffer is. The
    // capture samples the counter before this cycle's tick, which gives the
    // pre-tick value when the two coincide.
    // -----------------------------------------------------------------------
`ifdef CRON_LAP_EN
    localparam logic [LC_W-1:0] LAP_FULL = LC_W'(NUM_LAPS);

    logic             lap_req;
    logic [LC_W-1:0]  lap_cnt_q;
    logic [3:0]       lap_decs_q;
    logic [SEG_W-1:0] lap_segs_q;

    assign lap_req = cron_ev && (key_r == KEY_B) && running_q;

    always_ff @(posedge clk) begin
        if (!rst_n || sw_clear) begin
            lap_cnt_q  <= '0;
            lap_decs_q <= 4'd0;
            lap_segs_q <= '0;
        end else if (lap_req && lap_cnt_q != LAP_FULL) begin
            lap_cnt_q  <= lap_cnt_q + LC_W'(1);
            lap_decs_q <= decs_q;
            lap_segs_q <= segs_q;
        end
    end

    assign bus.lap_count = lap_cnt_q;
    assign bus.lap_decs  = lap_decs_q;
    assign bus.lap_segs  = lap_segs_q;
`else
    assign bus.lap_count = LC_W'(0);
    assign bus.lap_decs  = 4'd0;
    assign bus.lap_segs  = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.modo_atual = mode_q;
    assign bus.running    = running_q;
    assign bus.decs       = decs_q;
    assign bus.segs       = segs_q;
    assign bus.ovf        = ovf_q;
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.op         = op_q;
    assign bus.resultado  = res_q;

endmodule

// File: tb/tb_cron_calc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cron_calc_ctrl
//   Bench for cron_calc_ctrl with CLK_HZ=1000, SEG_W=2, OP_W=7, NUM_LAPS=2.
//   A reference model keeps elapsed time as one decisecond count and the
//   operands as plain integers. It is compared with every output on every
//   negative clock edge. Directed scenarios pin the model with literal
//   values, then random key traffic runs against the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cron_calc_ctrl;
    localparam int CLK_HZ   = 1000;
    localparam int SEG_W    = 2;
    localparam int OP_W     = 7;
    localparam int NUM_LAPS = 2;
    localparam int PRE_N    = CLK_HZ / 10;
    localparam int SW_WRAP  = (1 << SEG_W) * 10;   // deciseconds per wrap
    localparam int OP_MAX   = (1 << OP_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cron_calc_ctrl_if #(.SEG_W(SEG_W), .OP_W(OP_W), .NUM_LAPS(NUM_LAPS)) bus ();

    cron_calc_ctrl #(
        .CLK_HZ(CLK_HZ), .SEG_W(SEG_W), .OP_W(OP_W), .NUM_LAPS(NUM_LAPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_run, m_pre, m_t, m_ovf;
    int m_x, m_y, m_op, m_ptr, m_res;
    int m_lap_cnt, m_lap_t;
    int mk1, mk2, ev, t_before, cand;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_run = 0; m_pre = 0; m_t = 0; m_ovf = 0;
            m_x = 0; m_y = 0; m_op = 0; m_ptr = 0; m_res = 0;
            m_lap_cnt = 0; m_lap_t = 0;
            mk1 = 31; mk2 = 31;
        end else begin
            ev       = (mk1 != 31 && mk2 == 31) ? mk1 : -1;
            m_res    = (m_op != 0) ? m_x * m_y : m_x + m_y;
            t_before = m_t;
            if (m_run != 0) begin
                if (m_pre == PRE_N - 1) begin
                    m_pre = 0;
                    m_t++;
                    if (m_t == SW_WRAP) begin m_t = 0; m_ovf = 1; end
                end else begin
                    m_pre++;
                end
            end
            if (ev >= 0) begin
                if (m_mode == 0) begin
                    if (ev == 14 || ev == 15) m_mode = 1;
                    else if (ev == 10) m_run = 1 - m_run;
                    else if (ev == 11) begin
                        if (m_run != 0) begin
`ifdef CRON_LAP_EN
                            if (m_lap_cnt < NUM_LAPS) begin
                                m_lap_cnt++;
                                m_lap_t = t_before;
                            end
`endif
                        end else begin
                            m_t = 0; m_pre = 0; m_ovf = 0;
                            m_lap_cnt = 0; m_lap_t = 0;
                        end
                    end
                end else begin
                    if (ev == 13) m_mode = 0;
                    else if (ev <= 9) begin
                        cand = ((m_ptr != 0) ? m_y : m_x) * 10 + ev;
                        if (cand <= OP_MAX) begin
                            if (m_ptr != 0) m_y = cand;
                            else            m_x = cand;
                        end
                    end
                    else if (ev == 14) begin m_op = 1; m_ptr = 1; end
                    else if (ev == 15) begin m_op = 0; m_ptr = 1; end
                    else if (ev == 12) begin m_x = 0; m_y = 0; m_op = 0; m_ptr = 0; end
                end
            end
            mk2 = mk1;
            mk1 = int'(bus.key);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("modo_atual", bus.modo_atual, m_mode);
            check("running",    bus.running,    m_run);
            check("decs",       bus.decs,       m_t % 10);
            check("segs",       bus.segs,       m_t / 10);
            check("ovf",        bus.ovf,        m_ovf);
            check("X",          bus.X,          m_x);
            check("Y",          bus.Y,          m_y);
            check("op",         bus.op,         m_op);
            check("resultado",  bus.resultado,  m_res);
            check("lap_count",  bus.lap_count,  m_lap_cnt);
            check("lap_decs",   bus.lap_decs,   m_lap_t % 10);
            check("lap_segs",   bus.lap_segs,   m_lap_t / 10);
        end
    end

    // ---------------- driver tasks (always called at a negedge) ----------------
    // After press() returns, the effect of the press is visible on the outputs.
    task automatic press(input int k);
        bus.key = 5'(k);
        @(negedge clk);
        bus.key = 5'd31;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_modo"},  bus.modo_atual, 0);
        check({tag, "_run"},   bus.running,    0);
        check({tag, "_decs"},  bus.decs,       0);
        check({tag, "_segs"},  bus.segs,       0);
        check({tag, "_ovf"},   bus.ovf,        0);
        check({tag, "_X"},     bus.X,          0);
        check({tag, "_Y"},     bus.Y,          0);
        check({tag, "_op"},    bus.op,         0);
        check({tag, "_res"},   bus.resultado,  0);
        check({tag, "_lapc"},  bus.lap_count,  0);
        check({tag, "_lapd"},  bus.lap_decs,   0);
        check({tag, "_laps"},  bus.lap_segs,   0);
    endtask

    // ---------------- stimulus ----------------
    int changes, prev_mode, guard, k, r, hold, gap;

    initial begin
        bus.key = 5'd31;
        rst_n   = 1'b0;
        idle(3);
        chk_en = 1'b1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Holding * produces exactly one mode change.
        bus.key   = 5'd14;
        prev_mode = int'(bus.modo_atual);
        changes   = 0;
        repeat (5) begin
            @(negedge clk);
            if (int'(bus.modo_atual) != prev_mode) changes++;
            prev_mode = int'(bus.modo_atual);
        end
        bus.key = 5'd31;
        repeat (3) begin
            @(negedge clk);
            if (int'(bus.modo_atual) != prev_mode) changes++;
            prev_mode = int'(bus.modo_atual);
        end
        check("hold_star_changes", changes, 1);
        check("hold_star_mode", bus.modo_atual, 1);
        press(13);
        check("d_back_to_cron", bus.modo_atual, 0);

        // Start the stopwatch and run 1500 cycles: 1.5 s.
        press(10);
        check("start_running", bus.running, 1);
        idle(1499);
        check("t1499_decs", bus.decs, 4);
        idle(1);
        check("t1500_decs", bus.decs, 5);
        check("t1500_segs", bus.segs, 1);
        press(10);
        check("stop_running", bus.running, 0);
        idle(200);
        check("frozen_decs", bus.decs, 5);
        check("frozen_segs", bus.segs, 1);
        // The prescaler held 2 counts, so the next tick comes 98 cycles after restart.
        press(10);
        idle(97);
        check("resume_pre_decs", bus.decs, 5);
        idle(1);
        check("resume_tick_decs", bus.decs, 6);

        // Run up to 3.9 s, then one more tick wraps the counter and sets ovf.
        guard = 0;
        while (!(bus.segs == 2'd3 && bus.decs == 4'd9) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_3_9", guard < 5000, 1);
        check("pre_wrap_ovf", bus.ovf, 0);
        guard = 0;
        while (bus.decs == 4'd9 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wrap_seen", guard < 200, 1);
        check("wrap_segs", bus.segs, 0);
        check("wrap_decs", bus.decs, 0);
        check("wrap_ovf",  bus.ovf,  1);
        press(10);
        press(11);
        check("clr_ovf",  bus.ovf,  0);
        check("clr_decs", bus.decs, 0);
        check("clr_segs", bus.segs, 0);

        // Laps. The first B lands on the 11th tick and captures 1.0 (pre-tick).
        press(10);
        idle(1098);
        press(11);
        check("lap1_decs_now", bus.decs, 1);
        check("lap1_segs_now", bus.segs, 1);
`ifdef CRON_LAP_EN
        check("lap1_count", bus.lap_count, 1);
        check("lap1_segs",  bus.lap_segs,  1);
        check("lap1_decs",  bus.lap_decs,  0);
`else
        check("lap1_count", bus.lap_count, 0);
`endif
        idle(250);
        press(11);
        idle(130);
        press(11);
`ifdef CRON_LAP_EN
        check("lap3_count", bus.lap_count, 2);
        check("lap3_segs",  bus.lap_segs,  1);
        check("lap3_decs",  bus.lap_decs,  3);
`else
        check("lap3_count", bus.lap_count, 0);
        check("lap3_decs",  bus.lap_decs,  0);
`endif

        // Calculator entry.
        press(14);
        check("calc_mode", bus.modo_atual, 1);
        press(1); press(2); press(14); press(1); press(1);
        check("calc_X",  bus.X,  12);
        check("calc_Y",  bus.Y,  11);
        check("calc_op", bus.op, 1);
        check("calc_res_stale", bus.resultado, 12);
        idle(1);
        check("calc_res", bus.resultado, 132);
        press(9);
        check("calc_Y119", bus.Y, 119);
        press(9);
        check("calc_Y_drop", bus.Y, 119);
        idle(1);
        check("calc_res_1428", bus.resultado, 1428);
        press(12);
        check("calc_clr_X", bus.X, 0);
        check("calc_clr_op", bus.op, 0);
        press(13);
        check("calc_exit", bus.modo_atual, 0);

        // Random key traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r    = int'($urandom_range(0, 17));
            k    = (r <= 15) ? r : 31;
            hold = int'($urandom_range(1, 3));
            gap  = int'($urandom_range(0, 3));
            bus.key = 5'(k);
            idle(hold);
            bus.key = 5'd31;
            idle(gap);
        end
        idle(3);

        // Reset in CALC with X=5 while the stopwatch runs.
        if (m_mode == 1) press(13);
        if (m_run == 0) press(10);
        press(14);
        press(12);
        press(5);
        check("pre_rst_X",    bus.X,          5);
        check("pre_rst_run",  bus.running,    1);
        check("pre_rst_mode", bus.modo_atual, 1);
        rst_n = 1'b0;
        idle(1);
        check_all_zero("midrun_rst");
        rst_n = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
